// File: rtl/repair_arbiter.sv
// Fixed-priority branch-repair arbiter with a one-entry registered output slot.
// Optional per-source drop counters are built when REPAIR_STAT_EN is defined.
module repair_arbiter #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned CKPT_W  = 8,
  parameter int unsigned ACT_W   = 4,
  parameter int unsigned SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        SRC_valid_w_i,
  input  logic [NUM_SRC*ACT_W-1:0]  SRC_repairAction_w_i,
  input  logic [NUM_SRC*CKPT_W-1:0] SRC_checkPoint_w_i,
  input  logic [NUM_SRC*ADDR_W-1:0] SRC_erroVAddr_w_i,
  input  logic [NUM_SRC-1:0]        SRC_corrTake_w_i,
  input  logic [NUM_SRC*ADDR_W-1:0] SRC_corrDest_w_i,
  input  logic                      FU_kill_w_i,
  input  logic                      FU_ready_w_i,
  output logic                      FU_valid_w_o,
  output logic [SRC_W-1:0]          FU_src_w_o,
  output logic [ACT_W-1:0]          FU_repairAction_w_o,
  output logic [CKPT_W-1:0]         FU_allCheckPoint_w_o,
  output logic [ADDR_W-1:0]         FU_erroVAddr_w_o,
  output logic                      FU_correctTake_w_o,
  output logic [ADDR_W-1:0]         FU_correctDest_w_o
`ifdef REPAIR_STAT_EN
  ,
  output logic [NUM_SRC*16-1:0]     FU_dropCnt_w_o
`endif
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic [ACT_W-1:0]    act_q, act_d;
  logic [CKPT_W-1:0]   ckpt_q, ckpt_d;
  logic [ADDR_W-1:0]   vaddr_q, vaddr_d;
  logic                take_q, take_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;

  logic                win_found_c;
  logic [SRC_W-1:0]    win_idx_c;
  logic [ACT_W-1:0]    win_act_c;
  logic [CKPT_W-1:0]   win_ckpt_c;
  logic [ADDR_W-1:0]   win_vaddr_c;
  logic                win_take_c;
  logic [ADDR_W-1:0]   win_dest_c;
  logic                full_c, xfer_c, occ_c, load_c;

  // Priority encode: scanning downward lets the lowest valid index win.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    win_act_c   = '0;
    win_ckpt_c  = '0;
    win_vaddr_c = '0;
    win_take_c  = 1'b0;
    win_dest_c  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (SRC_valid_w_i[i]) begin
        win_found_c = 1'b1;
        win_idx_c   = SRC_W'(i);
        win_act_c   = SRC_repairAction_w_i[i*ACT_W +: ACT_W];
        win_ckpt_c  = SRC_checkPoint_w_i[i*CKPT_W +: CKPT_W];
        win_vaddr_c = SRC_erroVAddr_w_i[i*ADDR_W +: ADDR_W];
        win_take_c  = SRC_corrTake_w_i[i];
        win_dest_c  = SRC_corrDest_w_i[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign full_c = (state_q == ST_FULL);
  assign xfer_c = full_c & FU_ready_w_i;
  assign occ_c  = full_c & ~xfer_c;
  // Equal index replaces: the newer request comes from the redirected path.
  assign load_c = win_found_c & ~FU_kill_w_i & (~occ_c | (win_idx_c <= src_q));

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    act_d   = act_q;
    ckpt_d  = ckpt_q;
    vaddr_d = vaddr_q;
    take_d  = take_q;
    dest_d  = dest_q;
    if (FU_kill_w_i) begin
      state_d = ST_EMPTY;
    end else if (load_c) begin
      state_d = ST_FULL;
      src_d   = win_idx_c;
      act_d   = win_act_c;
      ckpt_d  = win_ckpt_c;
      vaddr_d = win_vaddr_c;
      take_d  = win_take_c;
      dest_d  = win_dest_c;
    end else if (xfer_c) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      src_q   <= '0;
      act_q   <= '0;
      ckpt_q  <= '0;
      vaddr_q <= '0;
      take_q  <= 1'b0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      act_q   <= act_d;
      ckpt_q  <= ckpt_d;
      vaddr_q <= vaddr_d;
      take_q  <= take_d;
      dest_q  <= dest_d;
    end
  end

  assign FU_valid_w_o         = full_c;
  assign FU_src_w_o           = src_q;
  assign FU_repairAction_w_o  = act_q;
  assign FU_allCheckPoint_w_o = ckpt_q;
  assign FU_erroVAddr_w_o     = vaddr_q;
  assign FU_correctTake_w_o   = take_q;
  assign FU_correctDest_w_o   = dest_q;

`ifdef REPAIR_STAT_EN
  logic [15:0] drop_cnt_q [NUM_SRC];
  logic [15:0] drop_cnt_d [NUM_SRC];

  // A valid request is dropped unless it is the winner that loads; kill cycles are not counted.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      drop_cnt_d[i] = drop_cnt_q[i];
      if (SRC_valid_w_i[i] && !FU_kill_w_i &&
          !(load_c && (win_idx_c == SRC_W'(i))) &&
          (drop_cnt_q[i] != 16'hFFFF)) begin
        drop_cnt_d[i] = drop_cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) drop_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) drop_cnt_q[i] <= drop_cnt_d[i];
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_drop_out
    assign FU_dropCnt_w_o[g*16 +: 16] = drop_cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_repair_arbiter.sv
// Scoreboard bench for repair_arbiter: directed scenarios plus random traffic
// checked against a behavioural slot model; transfers are compared by a monitor.
module tb_repair_arbiter;
  localparam int NS   = 3;
  localparam int AW   = 32;
  localparam int CW   = 8;
  localparam int ACTW = 4;
  localparam int SW   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NS-1:0]      src_valid = '0;
  logic [NS-1:0]      src_tk = '0;
  logic [NS*ACTW-1:0] src_act = '0;
  logic [NS*CW-1:0]   src_ck = '0;
  logic [NS*AW-1:0]   src_va = '0;
  logic [NS*AW-1:0]   src_dest = '0;
  logic               kill_i = 1'b0;
  logic               ready = 1'b0;

  logic               fu_valid;
  logic [SW-1:0]      fu_src;
  logic [ACTW-1:0]    fu_act;
  logic [CW-1:0]      fu_ck;
  logic [AW-1:0]      fu_va;
  logic               fu_tk;
  logic [AW-1:0]      fu_dest;
`ifdef REPAIR_STAT_EN
  logic [NS*16-1:0]   fu_drop;
`endif

  repair_arbiter #(.NUM_SRC(NS), .ADDR_W(AW), .CKPT_W(CW), .ACT_W(ACTW), .SRC_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .SRC_valid_w_i(src_valid), .SRC_repairAction_w_i(src_act),
    .SRC_checkPoint_w_i(src_ck), .SRC_erroVAddr_w_i(src_va),
    .SRC_corrTake_w_i(src_tk), .SRC_corrDest_w_i(src_dest),
    .FU_kill_w_i(kill_i), .FU_ready_w_i(ready),
    .FU_valid_w_o(fu_valid), .FU_src_w_o(fu_src),
    .FU_repairAction_w_o(fu_act), .FU_allCheckPoint_w_o(fu_ck),
    .FU_erroVAddr_w_o(fu_va), .FU_correctTake_w_o(fu_tk),
    .FU_correctDest_w_o(fu_dest)
`ifdef REPAIR_STAT_EN
    , .FU_dropCnt_w_o(fu_drop)
`endif
  );

  typedef struct {
    int            src;
    logic [ACTW-1:0] act;
    logic [CW-1:0]   ck;
    logic [AW-1:0]   va;
    logic            tk;
    logic [AW-1:0]   dest;
  } rep_t;

  rep_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // Reference model: one pending repair plus per-source drop tallies.
  bit   m_valid = 0;
  rep_t m_slot;
  int   m_cnt[NS];

  logic [ACTW-1:0] t_act[NS];
  logic [CW-1:0]   t_ck[NS];
  logic [AW-1:0]   t_va[NS];
  logic            t_tk[NS];
  logic [AW-1:0]   t_dest[NS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] va, input logic [AW-1:0] dest,
                         input logic tk);
    t_va[i] = va; t_dest[i] = dest; t_tk[i] = tk;
    t_act[i] = ACTW'(i + 1); t_ck[i] = CW'(8'hA0 + i);
  endtask

  task automatic rand_fields();
    for (int i = 0; i < NS; i++) begin
      t_va[i] = $urandom; t_dest[i] = $urandom; t_tk[i] = 1'($urandom);
      t_act[i] = ACTW'($urandom); t_ck[i] = CW'($urandom);
    end
  endtask

  // Drive one cycle of inputs and advance the model by the same cycle.
  task automatic step(input logic [NS-1:0] v, input logic kill, input logic rdy);
    int w;
    bit occ;
    bit ld;
    @(posedge clk); #1;
    src_valid = v; kill_i = kill; ready = rdy;
    for (int i = 0; i < NS; i++) begin
      src_act[i*ACTW +: ACTW] = t_act[i];
      src_ck[i*CW +: CW]      = t_ck[i];
      src_va[i*AW +: AW]      = t_va[i];
      src_tk[i]               = t_tk[i];
      src_dest[i*AW +: AW]    = t_dest[i];
    end
    if (m_valid && rdy) exp_q.push_back(m_slot);
    if (kill) begin
      m_valid = 0;
    end else begin
      w = -1;
      for (int i = NS - 1; i >= 0; i--) if (v[i]) w = i;
      occ = m_valid && !rdy;
      ld  = (w >= 0) && (!occ || w <= m_slot.src);
      for (int i = 0; i < NS; i++)
        if (v[i] && !(ld && i == w) && m_cnt[i] < 65535) m_cnt[i]++;
      if (ld) begin
        m_slot = '{w, t_act[w], t_ck[w], t_va[w], t_tk[w], t_dest[w]};
        m_valid = 1;
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic check_cnts(input string name);
`ifdef REPAIR_STAT_EN
    for (int i = 0; i < NS; i++)
      check($sformatf("%s_cnt%0d", name, i), 64'(fu_drop[i*16 +: 16]), 64'(m_cnt[i]));
`endif
  endtask

  // Monitor: every completed handshake must match the oldest expected transfer.
  always @(negedge clk) begin
    rep_t e;
    if (rst_n && fu_valid && ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL xfer: unexpected transfer src=%0d va=%0h, expected none", fu_src, fu_va);
      end else begin
        e = exp_q.pop_front();
        if (int'(fu_src) == e.src && fu_act == e.act && fu_ck == e.ck && fu_va == e.va &&
            fu_tk == e.tk && fu_dest == e.dest)
          n_pass++;
        else
          $display("FAIL xfer: got src=%0d va=%0h dest=%0h tk=%0b act=%0h ck=%0h, expected src=%0d va=%0h dest=%0h tk=%0b act=%0h ck=%0h",
                   fu_src, fu_va, fu_dest, fu_tk, fu_act, fu_ck,
                   e.src, e.va, e.dest, e.tk, e.act, e.ck);
      end
    end
  end

  initial begin
    for (int i = 0; i < NS; i++) begin
      m_cnt[i] = 0;
      set_src(i, '0, '0, 1'b0);
    end
    repeat (2) @(negedge clk);
    check("reset_valid", 64'(fu_valid), 64'd0);
    check("reset_fields", {fu_src, fu_va, fu_tk}, 64'd0);
    rst_n = 1'b1;

    // Single request from src1
    step('0, 0, 1); step('0, 0, 1);
    set_src(1, 32'hBFC00010, 32'hBFC00100, 1'b1);
    step(3'b010, 0, 1);
    step('0, 0, 1);
    check("single_valid", 64'(fu_valid), 64'd1);
    check("single_src", 64'(fu_src), 64'd1);
    check("single_va", 64'(fu_va), 64'hBFC00010);
    check("single_dest", 64'(fu_dest), 64'hBFC00100);
    check("single_tk", 64'(fu_tk), 64'd1);
    step('0, 0, 1);
    check("single_gone", 64'(fu_valid), 64'd0);

    // Simultaneous src0 and src1
    set_src(0, 32'h100, 32'h1100, 1'b0);
    set_src(1, 32'h200, 32'h1200, 1'b1);
    step(3'b011, 0, 1);
    step('0, 0, 1);
    check("simul_src", 64'(fu_src), 64'd0);
    check("simul_va", 64'(fu_va), 64'h100);
    check_cnts("simul");

    // Stall: same-priority replace, higher-priority replace, lower-priority drop
    set_src(1, 32'h200, 32'h2200, 1'b0);
    step(3'b010, 0, 0);
    set_src(1, 32'h300, 32'h2300, 1'b1);
    step(3'b010, 0, 0);
    set_src(0, 32'h400, 32'h2400, 1'b1);
    step(3'b001, 0, 0);
    check("stall_repl_va", 64'(fu_va), 64'h300);
    set_src(1, 32'h500, 32'h2500, 1'b0);
    step(3'b010, 0, 0);
    check("stall_hi_va", 64'(fu_va), 64'h400);
    check("stall_hi_src", 64'(fu_src), 64'd0);
    step('0, 0, 1);
    check("stall_drop_va", 64'(fu_va), 64'h400);
    step('0, 0, 1);
    check("stall_drained", 64'(fu_valid), 64'd0);
    check_cnts("stall");

    // Transfer plus load in the same cycle
    set_src(0, 32'h600, 32'h3600, 1'b0);
    step(3'b001, 0, 1);
    set_src(1, 32'h700, 32'h3700, 1'b1);
    step(3'b010, 0, 1);
    step('0, 0, 1);
    check("b2b_valid", 64'(fu_valid), 64'd1);
    check("b2b_src", 64'(fu_src), 64'd1);
    check("b2b_va", 64'(fu_va), 64'h700);
    step('0, 0, 1);

    // Kill with the slot full and src0 valid
    set_src(0, 32'h800, 32'h3800, 1'b0);
    step(3'b001, 0, 0);
    step(3'b011, 1, 0);
    step('0, 0, 0);
    check("kill_valid", 64'(fu_valid), 64'd0);
    check_cnts("kill");

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      logic [NS-1:0] v;
      rand_fields();
      for (int i = 0; i < NS; i++) v[i] = ($urandom_range(0, 99) < 40);
      step(v, $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 60);
    end
    for (int c = 0; c < 3; c++) step('0, 0, 1);
    check("rand_drained", 64'(fu_valid), 64'd0);
    check("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    check_cnts("rand");

    // Asynchronous reset mid-cycle with the slot full
    set_src(2, 32'h900, 32'h3900, 1'b1);
    step(3'b100, 0, 0);
    step('0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(fu_valid), 64'd0);
    check("arst_fields", {fu_src, fu_act, fu_ck, fu_tk}, 64'd0);
    check("arst_va", 64'(fu_va), 64'd0);
    check("arst_dest", 64'(fu_dest), 64'd0);
    m_valid = 0;
    exp_q.delete();
    for (int i = 0; i < NS; i++) m_cnt[i] = 0;
    check_cnts("arst");
    src_valid = '0; kill_i = 1'b0; ready = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;

    // Post-reset sanity
    set_src(2, 32'hA00, 32'h3A00, 1'b0);
    step(3'b100, 0, 1);
    step('0, 0, 1);
    check("post_src", 64'(fu_src), 64'd2);
    step('0, 0, 1);
    check("post_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
